// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file: controller
// state encoding and the default geometry.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_NREG = 32;

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: range and zero-entry checks, write-first bypass and the
// registered read data output.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREG     = DEFAULT_NREG,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [AW-1:0]   ra,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            busy,
    input  logic            wr_accept,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rd
);

    // One extra bit so NREG itself is representable when NREG is a power of two.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic            in_range;
    logic            is_zero;
    logic [XLEN-1:0] rd_reg;
    logic [XLEN-1:0] rd_next;

    // Choose the value to register: blanked, bypassed write data, or stored word.
    always_comb begin
        in_range = ({1'b0, ra} < NREG_W);
        is_zero  = (ZERO_REG != 0) && (ra == '0);
        rd_next  = mem_rdata;
        if (busy || !in_range || is_zero) begin
            rd_next = '0;
        end else if (wr_accept && (wa == ra)) begin
            rd_next = wdata;
        end
    end

    // Output register gives the one-cycle read latency.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_reg <= '0;
        end else begin
            rd_reg <= rd_next;
        end
    end

    assign rd = rd_reg;

endmodule

// File: rtl/reg_file_param.sv
// Parameterised multi-read-port register file with a serial clear after
// reset, write-first bypass and a rejected-write flag.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREG     = DEFAULT_NREG,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREAD*$clog2(NREG)-1:0] RA,
    input  logic [$clog2(NREG)-1:0]       WA,
    input  logic [XLEN-1:0]       WriteData,
    input  logic                  WE,
    output logic [NREAD*XLEN-1:0] RD,
    output logic                  Busy,
    output logic                  WrErr
);

    localparam int          AW       = $clog2(NREG);
    localparam logic [AW:0] NREG_W   = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt_reg;
    logic [AW-1:0]   clr_cnt_next;
    logic            wr_err_reg;
    logic            wr_err_next;
    logic            wa_ok;
    logic            wr_accept;
    logic            busy;

    // Single storage array, written by at most one source per cycle.
    logic [XLEN-1:0] mem [NREG];

    assign busy = (state_reg == CLEAR);

    // Next-state and write-acceptance decisions.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == CLEAR) begin
            if (clr_cnt_reg == LAST_IDX) begin
                state_next   = RUN;
                clr_cnt_next = '0;
            end else begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
            end
        end
        wa_ok       = ({1'b0, WA} < NREG_W) && !((ZERO_REG != 0) && (WA == '0));
        wr_accept   = WE && !Rst && !busy && wa_ok;
        wr_err_next = WE && !wr_accept;
    end

    // Controller registers; reset restarts the clear sequence from entry 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            wr_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            wr_err_reg  <= wr_err_next;
        end
    end

    // Storage write: the clear sequence owns the port while busy.
    always_ff @(posedge Clk) begin
        if (!Rst && busy) begin
            mem[clr_cnt_reg] <= '0;
        end else if (wr_accept) begin
            mem[WA] <= WriteData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rport
            logic [AW-1:0]   ra_port;
            logic [XLEN-1:0] rdata_raw;

            assign ra_port   = RA[gi*AW +: AW];
            assign rdata_raw = mem[ra_port];

            reg_file_read_port #(
                .XLEN     (XLEN),
                .NREG     (NREG),
                .ZERO_REG (ZERO_REG),
                .AW       (AW)
            ) u_rport (
                .Clk       (Clk),
                .Rst       (Rst),
                .ra        (ra_port),
                .mem_rdata (rdata_raw),
                .busy      (busy),
                .wr_accept (wr_accept),
                .wa        (WA),
                .wdata     (WriteData),
                .rd        (RD[gi*XLEN +: XLEN])
            );
        end
    endgenerate

    assign Busy  = busy;
    assign WrErr = wr_err_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with
// the cycle they are due; a monitor pops and compares on the falling edge.
module tb_reg_file_param;

    localparam int SIG_RD0 = 0, SIG_RD1 = 1, SIG_BUSY = 2, SIG_WRERR = 3,
                   SIG_RD2 = 4, SIG_BUSY2 = 5, SIG_WRERR2 = 6;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    // Instance 1: 32 entries, two read ports.
    logic        rst;
    logic [9:0]  ra;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [63:0] rd;
    logic        busy;
    logic        wrerr;
    // Instance 2: 24 entries, one read port.
    logic        rst2;
    logic [4:0]  ra2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic        we2;
    logic [31:0] rd2;
    logic        busy2;
    logic        wrerr2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    reg_file_param #(.XLEN(32), .NREG(32), .NREAD(2), .ZERO_REG(1)) dut (
        .Clk(clk), .Rst(rst), .RA(ra), .WA(wa), .WriteData(wd), .WE(we),
        .RD(rd), .Busy(busy), .WrErr(wrerr)
    );

    reg_file_param #(.XLEN(32), .NREG(24), .NREAD(1), .ZERO_REG(1)) dut2 (
        .Clk(clk), .Rst(rst2), .RA(ra2), .WA(wa2), .WriteData(wd2), .WE(we2),
        .RD(rd2), .Busy(busy2), .WrErr(wrerr2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(input int s);
        case (s)
            SIG_RD0:    return rd[31:0];
            SIG_RD1:    return rd[63:32];
            SIG_BUSY:   return {31'd0, busy};
            SIG_WRERR:  return {31'd0, wrerr};
            SIG_RD2:    return rd2;
            SIG_BUSY2:  return {31'd0, busy2};
            SIG_WRERR2: return {31'd0, wrerr2};
            default:    return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            SIG_RD0:    return "rd0";
            SIG_RD1:    return "rd1";
            SIG_BUSY:   return "busy";
            SIG_WRERR:  return "wrerr";
            SIG_RD2:    return "rd2";
            SIG_BUSY2:  return "busy2";
            SIG_WRERR2: return "wrerr2";
            default:    return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = pick(e.sig);
            total++;
            if (e.due != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", sname(e.sig), cyc, act, e.val);
            end else begin
                $display("ok   %s cycle %0d: %h", sname(e.sig), cyc, act);
            end
        end
    end

    task automatic expect_next(input int s, input logic [31:0] v);
        exp_t e;
        e.due = cyc + 1;
        e.sig = s;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        rst = r;
        we  = w;
        wa  = a;
        wd  = d;
        ra  = {r1, r0};
    endtask

    task automatic drive2(input logic r, input logic w, input logic [4:0] a,
                          input logic [31:0] d, input logic [4:0] r0);
        rst2 = r;
        we2  = w;
        wa2  = a;
        wd2  = d;
        ra2  = r0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        rst2 = 1'b1; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;

        // Reset both instances for one edge.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        drive2(1'b1, 1'b0, 5'd0, 32'd0, 5'd0);
        expect_next(SIG_BUSY, 32'd1);
        expect_next(SIG_RD0, 32'd0);
        expect_next(SIG_RD1, 32'd0);
        expect_next(SIG_WRERR, 32'd0);
        expect_next(SIG_BUSY2, 32'd1);

        // Clear sequence: Busy high for 32 cycles; a write mid-clear is rejected.
        for (int i = 0; i < 32; i++) begin
            if (i == 5) drive(1'b0, 1'b1, 5'd2, 32'h5555_5555, 5'd2, 5'd2);
            else        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2);
            drive2(1'b0, 1'b0, 5'd0, 32'd0, 5'd0);
            expect_next(SIG_BUSY, (i < 31) ? 32'd1 : 32'd0);
            expect_next(SIG_WRERR, (i == 5) ? 32'd1 : 32'd0);
            expect_next(SIG_RD0, 32'd0);
            if (i == 22) expect_next(SIG_BUSY2, 32'd1);
            if (i == 23) expect_next(SIG_BUSY2, 32'd0);
        end

        // Every entry reads zero after the clear.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            drive2(1'b0, 1'b0, 5'd0, 32'd0, 5'(i));
            expect_next(SIG_RD0, 32'd0);
            expect_next(SIG_RD1, 32'd0);
            expect_next(SIG_RD2, 32'd0);
        end

        // Write entry 5; instance 2 tries an out-of-range write.
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        drive2(1'b0, 1'b1, 5'd30, 32'h0000_1234, 5'd30);
        expect_next(SIG_WRERR, 32'd0);
        expect_next(SIG_RD0, 32'd0);
        expect_next(SIG_WRERR2, 32'd1);
        expect_next(SIG_RD2, 32'd0);

        // Both ports read entry 5; instance 2 writes its last entry.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        drive2(1'b0, 1'b1, 5'd23, 32'h0000_00AB, 5'd30);
        expect_next(SIG_RD0, 32'hDEAD_BEEF);
        expect_next(SIG_RD1, 32'hDEAD_BEEF);
        expect_next(SIG_WRERR, 32'd0);
        expect_next(SIG_WRERR2, 32'd0);
        expect_next(SIG_RD2, 32'd0);

        // Write 0x11 to entry 7 with bypass on port 1.
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0011, 5'd5, 5'd7);
        drive2(1'b0, 1'b0, 5'd0, 32'd0, 5'd23);
        expect_next(SIG_RD0, 32'hDEAD_BEEF);
        expect_next(SIG_RD1, 32'h0000_0011);
        expect_next(SIG_RD2, 32'h0000_00AB);

        // Overwrite entry 7 with 0x22 while port 0 reads it.
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd5);
        drive2(1'b0, 1'b0, 5'd0, 32'd0, 5'd30);
        expect_next(SIG_RD0, 32'h0000_0022);
        expect_next(SIG_RD1, 32'hDEAD_BEEF);
        expect_next(SIG_RD2, 32'd0);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        expect_next(SIG_RD0, 32'h0000_0022);
        expect_next(SIG_RD1, 32'h0000_0022);

        // Write to entry 0 is rejected and never bypassed.
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7);
        expect_next(SIG_WRERR, 32'd1);
        expect_next(SIG_RD0, 32'd0);
        expect_next(SIG_RD1, 32'h0000_0022);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd2);
        expect_next(SIG_WRERR, 32'd0);
        expect_next(SIG_RD0, 32'd0);
        expect_next(SIG_RD1, 32'd0);

        // Reset with WE high: no WrErr, read data cleared.
        drive(1'b1, 1'b1, 5'd9, 32'h0000_0099, 5'd5, 5'd5);
        expect_next(SIG_BUSY, 32'd1);
        expect_next(SIG_WRERR, 32'd0);
        expect_next(SIG_RD0, 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
            expect_next(SIG_BUSY, 32'd1);
        end

        // Reassert reset at clear cycle 10: a full 32-cycle clear follows.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        expect_next(SIG_BUSY, 32'd1);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
            expect_next(SIG_BUSY, (i < 31) ? 32'd1 : 32'd0);
            expect_next(SIG_RD0, 32'd0);
        end

        // Previously written entries are now zero.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
        expect_next(SIG_RD0, 32'd0);
        expect_next(SIG_RD1, 32'd0);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL provide parameter XLEN, default 32: data width in bits.
REQ-002 SHALL provide parameter NREG, default 32: number of entries, range 2..64.
REQ-003 SHALL provide parameter NREAD, default 2: number of read ports, range 1..4.
REQ-004 SHALL provide parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL derive localparam AW = clog2(NREG): address width.
REQ-006 SHALL have port Clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-007 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port RA, input, NREAD*AW bits: read addresses, port i in bits [i*AW +: AW].
REQ-009 SHALL have port WA, input, AW bits: write address.
REQ-010 SHALL have port WriteData, input, XLEN bits: write data.
REQ-011 SHALL have port WE, input, 1 bit: write enable.
REQ-012 SHALL have port RD, output, NREAD*XLEN bits: registered read data, port i in bits [i*XLEN +: XLEN].
REQ-013 SHALL have port Busy, output, 1 bit: high while the clear sequence runs.
REQ-014 SHALL have port WrErr, output, 1 bit: one-cycle pulse flagging a rejected write.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and RUN: CLEAR zeroes one entry per cycle by counter, then moves to RUN after entry NREG-1 (NREG cycles total).
REQ-016 SHALL drive Busy=1 exactly while the FSM is in CLEAR.
REQ-017 SHALL, in RUN, present on RD port i at cycle n+1 the contents of entry RA_i sampled at cycle n (1-cycle read latency).
REQ-018 SHALL, when WE=1 and WA==RA_i at the same edge and the write is accepted, forward WriteData to RD port i instead of the old value (write-first bypass).
REQ-019 SHALL return 0 on any read port addressing an entry >= NREG, addressing entry 0 with ZERO_REG=1, or issued while Busy=1.
REQ-020 SHALL accept a write at the rising edge only when WE=1, Busy=0, WA<NREG, and not (ZERO_REG=1 and WA==0).
REQ-021 SHALL assert WrErr for exactly the cycle after any edge where WE=1 and the write is not accepted; WrErr=0 otherwise.
REQ-022 SHALL handle all NREAD ports independently, including several ports reading the same address, and SHALL service all of them while a write proceeds.
REQ-023 SHALL hold RD at its last value when no new read data is produced; RD always reflects the most recent sampled addresses.

Reset
REQ-024 SHALL, when Rst=1 at a rising edge, enter CLEAR with counter=0 and set RD=0 and WrErr=0; Busy=1 from the next cycle.
REQ-025 SHALL restart the clear counter at 0 when Rst is reasserted during CLEAR.
REQ-026 SHALL ignore WE during Rst=1 without raising WrErr.
REQ-027 SHALL not rely on initial blocks for power-up contents; only the reset clear sequence defines register contents.

Structure
REQ-028 SHALL place the FSM state encoding (CLEAR, RUN) and default XLEN/NREG constants in the shared package reg_file_pkg.
REQ-029 SHALL instantiate sub-module reg_file_read_port once per read port; it holds the address decode, range/zero check, bypass mux, and RD output register.
REQ-030 SHALL keep storage as a single array so that the serial clear leaves the storage RAM-inferrable.

Verification
REQ-031 SHALL cover reset-clear timing: pulse Rst one cycle -> Busy=1 for exactly 32 cycles, then 0; every read after that returns 0.
REQ-032 SHALL cover write/read: write 0xDEADBEEF to entry 5, next cycle RA0=5 -> RD0=0xDEADBEEF one cycle later; RA1=5 at the same time -> same value.
REQ-033 SHALL cover bypass: entry 7 holds 0x11; WE=1, WA=7, WriteData=0x22, RA0=7 on the same edge -> RD0=0x22 next cycle.
REQ-034 SHALL cover zero register: ZERO_REG=1, write 0xFFFFFFFF to WA=0 -> WrErr pulses one cycle; reading entry 0 returns 0.
REQ-035 SHALL cover rejected writes: write during Busy -> WrErr=1 and entry unchanged. With NREG=24, WA=30 -> WrErr=1, and RA=30 reads 0.
REQ-036 SHALL cover reset mid-clear: reassert Rst at clear cycle 10 -> Busy remains 1 for 32 further cycles.
